wb_unit: RTL and testbench

WB_UNIT -- requirements
Module: wb_unit

---
 rtl/wb_unit_pkg.sv | 22 ++
 rtl/wb_load_ext.sv | 38 +++
 rtl/wb_unit.sv | 154 +++++++++++++++
 tb/tb_wb_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_unit_pkg.sv
// Shared writeback types: lane entry layout, load size encoding and lane limits.
package wb_unit_pkg;

    localparam int unsigned NLANE_MAX = 4;
    localparam int unsigned XLEN_MAX  = 64;

    typedef enum logic [1:0] {
        MsByte  = 2'd0,
        MsHalf  = 2'd1,
        MsWord  = 2'd2,
        MsDword = 2'd3
    } msize_e;

    typedef struct packed {
        logic                valid;
        logic                regwrite;
        logic [4:0]          dst;
        logic [XLEN_MAX-1:0] result;
        logic [XLEN_MAX-1:0] pc;
    } wb_lane_t;

endpackage

// File: rtl/wb_load_ext.sv
// Load result extension: truncates readdata to the access size, then sign/zero-extends.
// Instantiated by wb_unit only when WB_LOAD_EXT_EN is defined.
module wb_load_ext
    import wb_unit_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] readdata,
    input  logic [1:0]      msize,
    input  logic            msign,
    output logic [XLEN-1:0] ext
);

    int unsigned     bits;
    logic [XLEN-1:0] shifted;

    always_comb begin
        bits    = 64;
        shifted = readdata;
        ext     = readdata;
        unique case (msize_e'(msize))
            MsByte:  bits = 8;
            MsHalf:  bits = 16;
            MsWord:  bits = 32;
            default: bits = 64;
        endcase
        // Shift the field to the top, then back down arithmetically or logically.
        if (bits < XLEN) begin
            shifted = readdata << (XLEN - bits);
            if (msign) begin
                ext = $signed(shifted) >>> (XLEN - bits);
            end else begin
                ext = shifted >> (XLEN - bits);
            end
        end
    end

endmodule

// File: rtl/wb_unit.sv
// Writeback unit: 2-entry bundle FIFO feeding the register file, with retired-instruction count.
// Optional load extension is compiled in under WB_LOAD_EXT_EN.
module wb_unit
    import wb_unit_pkg::*;
#(
    parameter int unsigned NLANE = 2,
    parameter int unsigned XLEN  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NLANE-1:0]      in_lane_valid,
    input  logic [NLANE-1:0]      in_memtoreg,
    input  logic [NLANE-1:0]      in_regwrite,
    input  logic [NLANE-1:0]      in_msign,
    input  logic [NLANE*5-1:0]    in_dst,
    input  logic [NLANE*2-1:0]    in_msize,
    input  logic [NLANE*XLEN-1:0] in_aluout,
    input  logic [NLANE*XLEN-1:0] in_readdata,
    input  logic [NLANE*XLEN-1:0] in_pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  rf_ready,
    output logic [NLANE-1:0]      rf_wen,
    output logic [NLANE*5-1:0]    rf_waddr,
    output logic [NLANE*XLEN-1:0] rf_wdata,
    output logic [NLANE*XLEN-1:0] out_pc,
    output logic [NLANE-1:0]      out_lane_valid,
    output logic [63:0]           instret
);

    logic [1:0]      count_q, count_d;
    logic            wr_ptr_q, rd_ptr_q;
    logic [63:0]     instret_q, instret_d;
    logic            push, pop;
    logic [2:0]      retire_cnt;
    wb_lane_t        fifo_q   [2][NLANE];
    wb_lane_t        in_ent   [NLANE];
    wb_lane_t        head     [NLANE];
    logic [XLEN-1:0] load_val [NLANE];
    logic [XLEN-1:0] lane_res [NLANE];
    logic [NLANE-1:0] base_wen, kill_wen;

    for (genvar i = 0; i < NLANE; i++) begin : g_lane
`ifdef WB_LOAD_EXT_EN
        wb_load_ext #(
            .XLEN(XLEN)
        ) u_load_ext (
            .readdata(in_readdata[i*XLEN +: XLEN]),
            .msize   (in_msize[i*2 +: 2]),
            .msign   (in_msign[i]),
            .ext     (load_val[i])
        );
`else
        assign load_val[i] = in_readdata[i*XLEN +: XLEN];
`endif
        assign lane_res[i] = in_memtoreg[i] ? load_val[i] : in_aluout[i*XLEN +: XLEN];

        always_comb begin
            in_ent[i] = '{
                valid:    in_lane_valid[i],
                regwrite: in_regwrite[i],
                dst:      in_dst[i*5 +: 5],
                result:   XLEN_MAX'(lane_res[i]),
                pc:       XLEN_MAX'(in_pc[i*XLEN +: XLEN])
            };
        end
    end

`ifndef WB_LOAD_EXT_EN
    logic unused_load_cfg;
    assign unused_load_cfg = ^{in_msize, in_msign};
`endif

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & rf_ready;
    assign instret   = instret_q;

    always_comb begin
        retire_cnt = '0;
        for (int i = 0; i < int'(NLANE); i++) begin
            retire_cnt = retire_cnt + 3'(out_lane_valid[i]);
        end
        count_d   = count_q;
        instret_d = instret_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (push && !pop) count_d = count_q + 2'd1;
            if (!push && pop) count_d = count_q - 2'd1;
            if (pop) instret_d = instret_q + 64'(retire_cnt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            instret_q <= '0;
            for (int e = 0; e < 2; e++) begin
                for (int i = 0; i < int'(NLANE); i++) begin
                    fifo_q[e][i] <= '0;
                end
            end
        end else begin
            count_q   <= count_d;
            instret_q <= instret_d;
            if (flush) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (push) begin
                    for (int i = 0; i < int'(NLANE); i++) begin
                        fifo_q[wr_ptr_q][i] <= in_ent[i];
                    end
                    wr_ptr_q <= ~wr_ptr_q;
                end
                if (pop) rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Outputs are zero whenever the FIFO is empty, so reset forces them low immediately.
    always_comb begin
        rf_waddr       = '0;
        rf_wdata       = '0;
        out_pc         = '0;
        out_lane_valid = '0;
        base_wen       = '0;
        kill_wen       = '0;
        for (int i = 0; i < int'(NLANE); i++) begin
            head[i]           = fifo_q[rd_ptr_q][i];
            out_lane_valid[i] = out_valid & head[i].valid;
            base_wen[i]       = out_lane_valid[i] & head[i].regwrite & (head[i].dst != 5'd0);
            if (out_valid) begin
                rf_waddr[i*5 +: 5]    = head[i].dst;
                rf_wdata[i*XLEN +: XLEN] = head[i].result[XLEN-1:0];
                out_pc[i*XLEN +: XLEN]   = head[i].pc[XLEN-1:0];
            end
        end
        // A younger lane writing the same register supersedes the older one.
        for (int i = 0; i < int'(NLANE); i++) begin
            for (int j = i + 1; j < int'(NLANE); j++) begin
                if (base_wen[j] && (head[j].dst == head[i].dst)) kill_wen[i] = 1'b1;
            end
        end
        rf_wen = base_wen & ~kill_wen;
    end

endmodule

// File: tb/tb_wb_unit.sv
// Directed self-checking bench for wb_unit (NLANE=2, XLEN=64).
module tb_wb_unit;

    localparam int NL = 2;
    localparam int XL = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [NL-1:0]     in_lane_valid, in_memtoreg, in_regwrite, in_msign;
    logic [NL*5-1:0]   in_dst;
    logic [NL*2-1:0]   in_msize;
    logic [NL*XL-1:0]  in_aluout, in_readdata, in_pc;
    logic              flush;
    logic              out_valid;
    logic              rf_ready;
    logic [NL-1:0]     rf_wen;
    logic [NL*5-1:0]   rf_waddr;
    logic [NL*XL-1:0]  rf_wdata;
    logic [NL*XL-1:0]  out_pc;
    logic [NL-1:0]     out_lane_valid;
    logic [63:0]       instret;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    wb_unit #(
        .NLANE(NL),
        .XLEN (XL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_lane_valid (in_lane_valid),
        .in_memtoreg   (in_memtoreg),
        .in_regwrite   (in_regwrite),
        .in_msign      (in_msign),
        .in_dst        (in_dst),
        .in_msize      (in_msize),
        .in_aluout     (in_aluout),
        .in_readdata   (in_readdata),
        .in_pc         (in_pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .rf_ready      (rf_ready),
        .rf_wen        (rf_wen),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .out_pc        (out_pc),
        .out_lane_valid(out_lane_valid),
        .instret       (instret)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_lanes();
        in_lane_valid = '0;
        in_memtoreg   = '0;
        in_regwrite   = '0;
        in_msign      = '0;
        in_dst        = '0;
        in_msize      = '0;
        in_aluout     = '0;
        in_readdata   = '0;
        in_pc         = '0;
    endtask

    task automatic set_lane(input int l, input logic v, input logic rw, input logic m2r,
                            input logic [4:0] d, input logic [63:0] alu, input logic [63:0] rd,
                            input logic [63:0] pc, input logic [1:0] ms, input logic sg);
        in_lane_valid[l]        = v;
        in_regwrite[l]          = rw;
        in_memtoreg[l]          = m2r;
        in_dst[l*5 +: 5]        = d;
        in_aluout[l*XL +: XL]   = alu;
        in_readdata[l*XL +: XL] = rd;
        in_pc[l*XL +: XL]       = pc;
        in_msize[l*2 +: 2]      = ms;
        in_msign[l]             = sg;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        rf_ready = 1'b0;
        clr_lanes();
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_rf_wen", 64'(rf_wen), 64'd0);
        check_eq("rst_instret", instret, 64'd0);
        check_eq("rst_wdata", rf_wdata[63:0], 64'd0);
        check_eq("rst_lane_valid", 64'(out_lane_valid), 64'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);

        // Single-lane ALU writeback
        rf_ready = 1'b1;
        set_lane(0, 1, 1, 0, 5'd5, 64'h1234, 64'h0, 64'h100, 2'd0, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("single_valid", 64'(out_valid), 64'd1);
        check_eq("single_wen", 64'(rf_wen), 64'b01);
        check_eq("single_waddr", 64'(rf_waddr[4:0]), 64'd5);
        check_eq("single_wdata", rf_wdata[63:0], 64'h1234);
        check_eq("single_pc", out_pc[63:0], 64'h100);
        step();
        check_eq("single_instret", instret, 64'd1);
        check_eq("single_empty", 64'(out_valid), 64'd0);

        // Back-pressure: A, B fill the FIFO, C held upstream
        rf_ready = 1'b0;
        clr_lanes();
        set_lane(0, 1, 1, 0, 5'd1, 64'hA1, 64'h0, 64'h200, 2'd0, 0);
        in_valid = 1'b1;
        step();
        set_lane(0, 1, 1, 0, 5'd2, 64'hB2, 64'h0, 64'h204, 2'd0, 0);
        step();
        check_eq("bp_full_ready", 64'(in_ready), 64'd0);
        check_eq("bp_head_a", 64'(rf_waddr[4:0]), 64'd1);
        set_lane(0, 1, 1, 0, 5'd3, 64'hC3, 64'h0, 64'h208, 2'd0, 0);
        step();
        check_eq("bp_hold_ready", 64'(in_ready), 64'd0);
        check_eq("bp_hold_data", rf_wdata[63:0], 64'hA1);
        check_eq("bp_hold_instret", instret, 64'd1);
        rf_ready = 1'b1;
        step();
        check_eq("bp_drain_b", rf_wdata[63:0], 64'hB2);
        check_eq("bp_drain_b_pc", out_pc[63:0], 64'h204);
        step();
        in_valid = 1'b0;
        check_eq("bp_drain_c", rf_wdata[63:0], 64'hC3);
        check_eq("bp_ready_again", 64'(in_ready), 64'd1);
        step();
        check_eq("bp_empty", 64'(out_valid), 64'd0);
        check_eq("bp_instret", instret, 64'd4);

        // Same destination in both lanes: younger lane wins
        clr_lanes();
        set_lane(0, 1, 1, 0, 5'd7, 64'hA, 64'h0, 64'h300, 2'd0, 0);
        set_lane(1, 1, 1, 0, 5'd7, 64'hB, 64'h0, 64'h304, 2'd0, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("samedst_wen", 64'(rf_wen), 64'b10);
        check_eq("samedst_waddr1", 64'(rf_waddr[9:5]), 64'd7);
        check_eq("samedst_wdata1", rf_wdata[127:64], 64'hB);
        step();
        check_eq("samedst_instret", instret, 64'd6);

        // x0 destination retires without writing
        clr_lanes();
        set_lane(0, 1, 1, 0, 5'd0, 64'h55, 64'h0, 64'h400, 2'd0, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("x0_wen", 64'(rf_wen), 64'd0);
        check_eq("x0_lane_valid", 64'(out_lane_valid), 64'b01);
        step();
        check_eq("x0_instret", instret, 64'd7);

        // Loads: signed byte on lane 0, unsigned half on lane 1
        clr_lanes();
        set_lane(0, 1, 1, 1, 5'd9, 64'hDEAD, 64'h80, 64'h500, 2'd0, 1);
        set_lane(1, 1, 1, 1, 5'd10, 64'hBEEF, 64'hFFFF_8001, 64'h504, 2'd1, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("load_wen", 64'(rf_wen), 64'b11);
`ifdef WB_LOAD_EXT_EN
        check_eq("load_sb", rf_wdata[63:0], 64'hFFFF_FFFF_FFFF_FF80);
        check_eq("load_uh", rf_wdata[127:64], 64'h8001);
`else
        check_eq("load_sb", rf_wdata[63:0], 64'h80);
        check_eq("load_uh", rf_wdata[127:64], 64'hFFFF_8001);
`endif
        step();
        check_eq("load_instret", instret, 64'd9);

        // Flush with a full FIFO and a pop pending
        rf_ready = 1'b0;
        clr_lanes();
        set_lane(0, 1, 1, 0, 5'd4, 64'h44, 64'h0, 64'h600, 2'd0, 0);
        in_valid = 1'b1;
        step();
        step();
        check_eq("flush2_full", 64'(in_ready), 64'd0);
        rf_ready = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush2_valid", 64'(out_valid), 64'd0);
        check_eq("flush2_ready", 64'(in_ready), 64'd1);
        check_eq("flush2_instret", instret, 64'd9);

        // Flush with count=1 and a same-cycle push and pop
        rf_ready = 1'b0;
        in_valid = 1'b1;
        step();
        rf_ready = 1'b1;
        flush    = 1'b1;
        set_lane(0, 1, 1, 0, 5'd6, 64'h66, 64'h0, 64'h700, 2'd0, 0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush1_valid", 64'(out_valid), 64'd0);
        check_eq("flush1_instret", instret, 64'd9);

        // Continuous traffic across pointer wrap
        clr_lanes();
        rf_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_lane(0, 1, 1, 0, 5'(11 + k), 64'h1000 + 64'(k), 64'h0, 64'h800, 2'd0, 0);
            set_lane(1, 1, 1, 0, 5'(20 + k), 64'h2000 + 64'(k), 64'h0, 64'h804, 2'd0, 0);
            step();
            check_eq("stream_lane0", rf_wdata[63:0], 64'h1000 + 64'(k));
            check_eq("stream_lane1", rf_wdata[127:64], 64'h2000 + 64'(k));
            check_eq("stream_wen", 64'(rf_wen), 64'b11);
        end
        in_valid = 1'b0;
        step();
        check_eq("stream_empty", 64'(out_valid), 64'd0);
        check_eq("stream_instret", instret, 64'd17);

        // Reset mid-operation with two bundles buffered
        rf_ready = 1'b0;
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check_eq("midrst_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_wen", 64'(rf_wen), 64'd0);
        check_eq("midrst_instret", instret, 64'd0);
        step();
        reset = 1'b0;
        step();
        check_eq("midrst_after", 64'(out_valid), 64'd0);
        check_eq("midrst_ready", 64'(in_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
